countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- MM:SS countdown timer that consumes the one-cycle 1 Hz tick produced by the project clock divider.
- Holds its count in four BCD digits, driven directly into the seven-segment display driver.
- Run/pause/load control comes from debounced single-cycle button pulses.
- Raises an alarm when the count reaches 00:00.

Parameters:
ALARM_TICKS, 5, number of tick pulses the alarm stays asserted in DONE before auto-return to IDLE (legal 1..255)

Ports:
clkIn  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
tick  input  1  one-clkIn-cycle enable pulse, 1 Hz, from clock divider
start  input  1  single-cycle pulse: start / pause / resume / silence
load  input  1  single-cycle pulse: copy preset digits into counter
preset_min_tens  input  4  BCD preset, minutes tens
preset_min_ones  input  4  BCD preset, minutes ones
preset_sec_tens  input  4  BCD preset, seconds tens
preset_sec_ones  input  4  BCD preset, seconds ones
min_tens  output  4  current count, minutes tens (BCD)
min_ones  output  4  current count, minutes ones (BCD)
sec_tens  output  4  current count, seconds tens (BCD)
sec_ones  output  4  current count, seconds ones (BCD)
state  output  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
done  output  1  one-cycle pulse on reaching 00:00
alarm  output  1  level, high while in DONE

Behaviour:
- All outputs are registered and update on posedge clkIn.
- Reset (reset=0, async) forces:
  - all four digits 0;
  - state IDLE;
  - done 0, alarm 0;
  - alarm tick counter 0.
  - Reset mid-RUN or mid-DONE aborts immediately; there is no pending state.
- Load clamping: a digit >9 loads as 9; sec_tens >5 loads as 5. Preset 7F:9A loads as 79:59.
- Priority in one cycle: load > start > tick. All decisions use the state value before the clock edge.
- IDLE:
  - load: copy clamped preset; stay IDLE.
  - start with count != 00:00: go to RUN.
  - start with count == 00:00: ignored.
  - tick: ignored.
- RUN:
  - start: go to PAUSED; the count is frozen.
  - load: ignored.
  - tick: decrement by one second.
    - sec_ones 0 wraps to 9 and borrows from sec_tens.
    - sec_tens 0 wraps to 5 and borrows from min_ones.
    - min_ones 0 wraps to 9 and borrows from min_tens.
  - tick while count == 00:01:
    - count becomes 00:00;
    - state becomes DONE in the same edge;
    - done=1 for exactly one cycle;
    - alarm=1;
    - alarm counter cleared.
- PAUSED:
  - tick: ignored.
  - start: go to RUN.
  - load: copy clamped preset; go to IDLE.
- DONE:
  - count holds at 00:00; alarm=1.
  - Each tick increments the alarm counter.
  - On the tick that makes the counter equal ALARM_TICKS: go to IDLE, alarm=0.
  - start: go to IDLE, alarm=0 (silence).
  - load: copy preset, go to IDLE, alarm=0.
- RUN with count 00:00 is unreachable: entry is blocked in IDLE, and PAUSED is only entered from RUN with a nonzero count.
- Same-cycle events:
  - start+tick in IDLE: enter RUN; no decrement this cycle.
  - start+tick in RUN: go to PAUSED; no decrement.
  - start+tick in PAUSED: go to RUN; no decrement.
- done is never asserted except on the RUN→DONE edge. alarm equals (state==DONE) at all times.
- Digits are always valid BCD. Seconds tens is never >5.
- Latency: a count change appears on the edge where tick=1 is sampled.

Test Plan:
- Reset: pulse reset=0 mid-RUN at 12:34 → next sample shows digits 00:00, state 00, done 0, alarm 0.
- Load clamp: load with presets 7,15,9,12 → 79:59, state IDLE. A following start → state 01.
- Borrow chain: load 10:00, start, one tick → 09:59. Load 01:00, start, tick → 00:59.
- Terminal count: load 00:02, start, two ticks → after 2nd tick digits 00:00, state 11, done high exactly one cycle, alarm 1. After 5 more ticks → state 00, alarm 0.
- Pause/resume: load 00:30, start, 3 ticks → 00:27. Start, 4 ticks → still 00:27, state 10. Start, tick → 00:26.
- Corner pulses:
  - start with count 00:00 in IDLE → stays IDLE.
  - start+tick same cycle in IDLE at 00:05 → RUN, count 00:05.
  - load during RUN → ignored.
  - start in DONE → IDLE, alarm 0 immediately.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with run/pause/load control and a timed alarm
module countdown_timer #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       load,
  input  logic [3:0] preset_min_tens,
  input  logic [3:0] preset_min_ones,
  input  logic [3:0] preset_sec_tens,
  input  logic [3:0] preset_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       done,
  output logic       alarm
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, DONE = 2'b11} state_t;
  state_t     cur, nxt;
  logic [3:0] mt_n, mo_n, st_n, so_n;
  logic [3:0] l_mt, l_mo, l_st, l_so;
  logic [3:0] d_mt, d_mo, d_st, d_so;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic       done_n, zero, one, b_so, b_st, b_mo;
  assign state   = cur;
  assign l_mt    = preset_min_tens > 4'd9 ? 4'd9 : preset_min_tens;
  assign l_mo    = preset_min_ones > 4'd9 ? 4'd9 : preset_min_ones;
  assign l_st    = preset_sec_tens > 4'd5 ? 4'd5 : preset_sec_tens;
  assign l_so    = preset_sec_ones > 4'd9 ? 4'd9 : preset_sec_ones;
  assign zero    = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
  assign one     = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0001;
  assign b_so    = sec_ones == 4'd0;
  assign b_st    = b_so && sec_tens == 4'd0;
  assign b_mo    = b_st && min_ones == 4'd0;
  assign d_so    = b_so ? 4'd9 : sec_ones - 4'd1;
  assign d_st    = b_so ? (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1) : sec_tens;
  assign d_mo    = b_st ? (min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1) : min_ones;
  assign d_mt    = b_mo ? min_tens - 4'd1 : min_tens;
  assign cnt_inc = cnt + 8'd1;
  // Register state, digits, alarm counter and the registered done/alarm outputs
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      cur      <= IDLE;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      cnt      <= 8'd0;
      done     <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      cur      <= nxt;
      min_tens <= mt_n;
      min_ones <= mo_n;
      sec_tens <= st_n;
      sec_ones <= so_n;
      cnt      <= cnt_n;
      done     <= done_n;
      alarm    <= nxt == DONE;
    end
  end
  // Next-state and next-count decisions; load beats start beats tick
  always_comb begin
    nxt    = cur;
    mt_n   = min_tens;
    mo_n   = min_ones;
    st_n   = sec_tens;
    so_n   = sec_ones;
    cnt_n  = cnt;
    done_n = 1'b0;
    case (cur)
      IDLE: begin
        if (load) begin
          {mt_n, mo_n, st_n, so_n} = {l_mt, l_mo, l_st, l_so};
        end else if (start && !zero) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (start) begin
          nxt = PAUSED;
        end else if (tick) begin
          {mt_n, mo_n, st_n, so_n} = {d_mt, d_mo, d_st, d_so};
          if (one) begin
            nxt    = DONE;
            done_n = 1'b1;
            cnt_n  = 8'd0;
          end
        end
      end
      PAUSED: begin
        if (load) begin
          {mt_n, mo_n, st_n, so_n} = {l_mt, l_mo, l_st, l_so};
          nxt = IDLE;
        end else if (start) begin
          nxt = RUN;
        end
      end
      default: begin
        if (load) begin
          {mt_n, mo_n, st_n, so_n} = {l_mt, l_mo, l_st, l_so};
          nxt = IDLE;
        end else if (start) begin
          nxt = IDLE;
        end else if (tick) begin
          cnt_n = cnt_inc;
          nxt   = cnt_inc == 8'(ALARM_TICKS) ? IDLE : DONE;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors with a queued scoreboard and a decoupled monitor
module tb_countdown_timer;
  logic       clkIn = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, start = 1'b0, load = 1'b0;
  logic [3:0] p_mt = 4'd0, p_mo = 4'd0, p_st = 4'd0, p_so = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       done, alarm;
  typedef struct {
    int         id;
    logic [15:0] d;
    logic [1:0] s;
    logic       dn;
    logic       al;
  } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   vec = 0;
  countdown_timer #(.ALARM_TICKS(5)) dut (
    .clkIn(clkIn), .reset(reset), .tick(tick), .start(start), .load(load),
    .preset_min_tens(p_mt), .preset_min_ones(p_mo),
    .preset_sec_tens(p_st), .preset_sec_ones(p_so),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .done(done), .alarm(alarm)
  );
  always #5 clkIn = ~clkIn;
  // Monitor: each cycle the DUT presents a result for the previous stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clkIn);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} === e.d && state === e.s &&
            done === e.dn && alarm === e.al)
          passed++;
        else
          $display("FAIL vec%0d: got %h st=%b done=%b alarm=%b, want %h st=%b done=%b alarm=%b",
                   e.id, {min_tens, min_ones, sec_tens, sec_ones}, state, done, alarm,
                   e.d, e.s, e.dn, e.al);
      end
    end
  end
  task automatic push(input logic [15:0] d, input logic [1:0] s, input logic dn, input logic al);
    exp_t e;
    e.id = vec; e.d = d; e.s = s; e.dn = dn; e.al = al;
    exp_q.push_back(e);
    vec++;
  endtask
  task automatic step(input logic ld, input logic st, input logic tk,
                      input logic [15:0] d, input logic [1:0] s, input logic dn, input logic al);
    @(negedge clkIn);
    load = ld; start = st; tick = tk;
    push(d, s, dn, al);
  endtask
  task automatic do_reset();
    @(negedge clkIn);
    load = 0; start = 0; tick = 0; reset = 0;
    push(16'h0000, 2'b00, 0, 0);
    @(negedge clkIn);
    reset = 1;
    push(16'h0000, 2'b00, 0, 0);
  endtask
  task automatic preset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    p_mt = a; p_mo = b; p_st = c; p_so = d;
  endtask
  initial begin
    do_reset();
    step(0, 1, 0, 16'h0000, 2'b00, 0, 0);
    preset(4'd7, 4'd15, 4'd9, 4'd12);
    step(1, 0, 0, 16'h7959, 2'b00, 0, 0);
    step(0, 1, 0, 16'h7959, 2'b01, 0, 0);
    step(0, 0, 1, 16'h7958, 2'b01, 0, 0);
    preset(4'd1, 4'd0, 4'd0, 4'd0);
    step(1, 0, 0, 16'h7958, 2'b01, 0, 0);
    step(0, 1, 0, 16'h7958, 2'b10, 0, 0);
    step(1, 0, 0, 16'h1000, 2'b00, 0, 0);
    step(0, 1, 0, 16'h1000, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0959, 2'b01, 0, 0);
    step(0, 1, 0, 16'h0959, 2'b10, 0, 0);
    preset(4'd0, 4'd1, 4'd0, 4'd0);
    step(1, 0, 0, 16'h0100, 2'b00, 0, 0);
    step(0, 1, 0, 16'h0100, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0059, 2'b01, 0, 0);
    step(0, 1, 0, 16'h0059, 2'b10, 0, 0);
    preset(4'd1, 4'd2, 4'd3, 4'd4);
    step(1, 0, 0, 16'h1234, 2'b00, 0, 0);
    step(0, 1, 0, 16'h1234, 2'b01, 0, 0);
    do_reset();
    preset(4'd0, 4'd0, 4'd0, 4'd2);
    step(1, 0, 0, 16'h0002, 2'b00, 0, 0);
    step(0, 1, 0, 16'h0002, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0001, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0000, 2'b11, 1, 1);
    step(0, 0, 0, 16'h0000, 2'b11, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0000, 2'b11, 0, 1);
    step(0, 0, 1, 16'h0000, 2'b00, 0, 0);
    preset(4'd0, 4'd0, 4'd3, 4'd0);
    step(1, 0, 0, 16'h0030, 2'b00, 0, 0);
    step(0, 1, 0, 16'h0030, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0029, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0028, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0027, 2'b01, 0, 0);
    step(0, 1, 0, 16'h0027, 2'b10, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0027, 2'b10, 0, 0);
    step(0, 1, 0, 16'h0027, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0026, 2'b01, 0, 0);
    step(0, 1, 1, 16'h0026, 2'b10, 0, 0);
    step(0, 1, 1, 16'h0026, 2'b01, 0, 0);
    step(0, 1, 0, 16'h0026, 2'b10, 0, 0);
    preset(4'd0, 4'd0, 4'd0, 4'd5);
    step(1, 0, 0, 16'h0005, 2'b00, 0, 0);
    step(0, 1, 1, 16'h0005, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0004, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0003, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0002, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0001, 2'b01, 0, 0);
    step(0, 0, 1, 16'h0000, 2'b11, 1, 1);
    step(0, 1, 0, 16'h0000, 2'b00, 0, 0);
    preset(4'd10, 4'd9, 4'd6, 4'd9);
    step(1, 0, 0, 16'h9959, 2'b00, 0, 0);
    step(0, 0, 0, 16'h9959, 2'b00, 0, 0);
    repeat (3) @(negedge clkIn);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
